gui_panel: RTL and testbench
============================

Name: gui_panel

Overview:
- Parametrised successor of the single-swatch GUI sprite; draws the left-hand tool panel overlay for the drawing canvas.
- Draws, on a gray background:
  - a current-colour preview with a blinking outline;
  - a 16-entry palette grid with the selected entry outlined;
  - a stroke-width bar.
- Sits in the video path beside the canvas framebuffer read. The downstream mux selects panel pixels when in_sprite is high.
- Cursor colour and stroke width are shadowed once per frame, so the panel never tears mid-frame.

Parameters:
- PANEL_W, 100: panel occupies hcount_in in [0, PANEL_W].
- SWATCH_PX, 20: side length in pixels of each palette cell.
- GRID_Y0, 120: top row (vcount) of the palette grid.
- STROKE_STEP, 10: bar growth in pixels per stroke_width unit.
- BAR_BOT, 700: bottom row of the stroke bar. The bar base (zero-width stroke) is at BAR_BOT-20.
- BLINK_FRAMES, 30: frames per blink half-period. Minimum 1.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  synchronous active-high reset.
- new_frame_in  input  1  one-cycle pulse at frame start.
- cursor_color  input  4  palette index of the active pen colour.
- stroke_width  input  3  pen width, 0..7.
- hcount_in  input  11  pixel x.
- vcount_in  input  10  pixel y.
- red_out  output  8  panel red.
- green_out  output  8  panel green.
- blue_out  output  8  panel blue.
- in_sprite  output  1  high when the delayed pixel lies in the panel.

Behaviour:

Clock and reset:
- One clock domain. Synchronous active-high reset.
- Reset values:
  - red_out, green_out, blue_out = 0; in_sprite = 0.
  - Shadow colour = 4'h1 (white); shadow width = 0.
  - Blink counter = 0; blink phase = 1 (outline visible).
  - All pipeline registers cleared.
- Reset mid-frame:
  - Outputs are 0 on the cycle after rst_in is sampled high.
  - Drawing resumes with reset shadows; new_frame_in is not required.

Shadow registers:
- On a cycle with new_frame_in=1, cursor_color and stroke_width are captured at that clock edge.
- A pixel presented in the same cycle as the pulse uses the pre-update shadows.

Blink:
- Counter increments on each new_frame_in.
- On reaching BLINK_FRAMES-1 with a pulse, the counter wraps to 0 and the blink phase toggles.

Palette:
- 16-entry fixed RGB ROM, indices 0..15, in this order:
  - black 000000, white FFFFFF, red FF0000, green 00FF00;
  - blue 0000FF, cyan 00FFFF, magenta FF00FF, yellow FFFF00;
  - gray 808080, eminence 6C3082, pink FF0080, orange FF8000;
  - purple 8000FF, cool blue 0080FF, mint 00FF80, lime 80FF00.

Pipeline (total latency 2 cycles, pixel to output):
- Stage 1 registers:
  - region flags;
  - grid row = (vcount-GRID_Y0)/SWATCH_PX and column;
  - a cell-edge flag;
  - the in-panel flag.
- Stage 2 looks up the ROM and registers the RGB outputs and in_sprite.

Region priority (first match wins), all bounds inclusive unless stated:
1. Preview outline: x,y in [18,82] but not in [20,80], and blink phase=1 → FFFFFF. When phase=0 these pixels fall through to background.
2. Preview: x,y in [20,80] → ROM[shadow colour].
3. Palette grid: y in [GRID_Y0, GRID_Y0+8*SWATCH_PX).
   - Column 0: x in [20, 20+SWATCH_PX). Column 1: x in [60, 60+SWATCH_PX).
   - Index = column*8 + row.
   - If index == shadow colour and the pixel is on the outer 1-px ring of the cell → FFFFFF.
   - Otherwise → ROM[index].
4. Stroke bar: x in [40,60] and y in [BAR_BOT-20-STROKE_STEP*width, BAR_BOT] → B9B9B9. Arithmetic is 11-bit unsigned; no underflow for legal parameters.
5. Any other pixel with x ≤ PANEL_W → 505050.

Outside the panel:
- x > PANEL_W: in_sprite=0 and RGB=0.

Optional Feature:
- Macro: GUI_PANEL_BLINK_EN.
- Defined: the blink counter and phase toggle exist exactly as described above.
- Undefined: no blink counter is built; the blink phase is constantly 1 and the preview outline is always drawn.
- The shadow registers behave identically in both builds.

Test Plan:
- Reset → after rst_in high for 1 cycle: in_sprite=0, RGB=0. Then pixel (50,50) with no frame pulse → 2 cycles later RGB=FFFFFF (shadow white), in_sprite=1.
- cursor_color=4'h9, new_frame_in pulse, then pixel (50,50) → RGB=6C3082 after 2 cycles. Change cursor_color to 4'h2 without a pulse → pixel (50,50) still 6C3082.
- Shadow colour=10 (column 1, row 2). Pixel (60,160) → FFFFFF (outline ring). Pixel (70,170) → FF0080. Pixel (30,130) → ROM[0] = 000000.
- stroke_width=3 latched. Pixel (50,650) → B9B9B9. Pixel (50,649) → 505050. Pixel (101,650) → in_sprite=0, RGB=0.
- BLINK_FRAMES=2 with GUI_PANEL_BLINK_EN defined:
  - pulses 1–2 → pixel (19,50) is FFFFFF, then 505050 after pulse 2;
  - white again after pulse 4.
  - With the macro undefined, the pixel is always FFFFFF.
- Same-cycle new_frame_in and pixel (50,50) with a new cursor_color → that pixel shows the old colour; the next pixel shows the new colour.

Source files
------------

// File: rtl/gui_panel.sv
// Left-hand tool panel overlay: colour preview with blinking outline, 16-entry palette grid, stroke-width bar.
// Latency 2 cycles pixel-to-output; no backpressure. Optional blink built only when GUI_PANEL_BLINK_EN is defined.
module gui_panel #(
    parameter int PANEL_W      = 100,
    parameter int SWATCH_PX    = 20,
    parameter int GRID_Y0      = 120,
    parameter int STROKE_STEP  = 10,
    parameter int BAR_BOT      = 700,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic [3:0]  cursor_color,
    input  logic [2:0]  stroke_width,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        in_sprite
);

    localparam logic [10:0] PW       = 11'(PANEL_W);
    localparam logic [10:0] SW       = 11'(SWATCH_PX);
    localparam logic [10:0] GY0      = 11'(GRID_Y0);
    localparam logic [10:0] GY1      = 11'(GRID_Y0 + 8 * SWATCH_PX);
    localparam logic [10:0] BAR_BASE = 11'(BAR_BOT - 20);
    localparam logic [10:0] BAR_END  = 11'(BAR_BOT);
    localparam logic [10:0] STEP     = 11'(STROKE_STEP);

    function automatic logic [23:0] rom(input logic [3:0] idx);
        case (idx)
            4'd0:    rom = 24'h000000;
            4'd1:    rom = 24'hFFFFFF;
            4'd2:    rom = 24'hFF0000;
            4'd3:    rom = 24'h00FF00;
            4'd4:    rom = 24'h0000FF;
            4'd5:    rom = 24'h00FFFF;
            4'd6:    rom = 24'hFF00FF;
            4'd7:    rom = 24'hFFFF00;
            4'd8:    rom = 24'h808080;
            4'd9:    rom = 24'h6C3082;
            4'd10:   rom = 24'hFF0080;
            4'd11:   rom = 24'hFF8000;
            4'd12:   rom = 24'h8000FF;
            4'd13:   rom = 24'h0080FF;
            4'd14:   rom = 24'h00FF80;
            default: rom = 24'h80FF00;
        endcase
    endfunction

    function automatic logic in_rng(input logic [10:0] v, input logic [10:0] lo, input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic [3:0] shadow_color;
    logic [2:0] shadow_width;
    logic       blink_phase;

    // Shadows only move at frame start so a frame is drawn with one consistent colour/width.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_color <= 4'h1;
            shadow_width <= 3'd0;
        end else if (new_frame_in) begin
            shadow_color <= cursor_color;
            shadow_width <= stroke_width;
        end
    end

`ifdef GUI_PANEL_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CW-1:0] blink_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (new_frame_in) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign blink_phase = (BLINK_FRAMES >= 1);
`endif

    // Stage 1: geometry classification against the current (pre-update) shadows.
    logic [10:0] x, y, dx, dy, ry, bar_top;
    logic        sq18, sq20, col0, col1, grid_y, cell_edge, bar;
    logic [2:0]  row;

    assign x       = hcount_in;
    assign y       = {1'b0, vcount_in};
    assign sq18    = in_rng(x, 11'd18, 11'd82) && in_rng(y, 11'd18, 11'd82);
    assign sq20    = in_rng(x, 11'd20, 11'd80) && in_rng(y, 11'd20, 11'd80);
    assign col0    = (x >= 11'd20) && (x < 11'd20 + SW);
    assign col1    = (x >= 11'd60) && (x < 11'd60 + SW);
    assign grid_y  = (y >= GY0) && (y < GY1);
    assign dy      = y - GY0;
    assign dx      = col1 ? (x - 11'd60) : (x - 11'd20);
    assign ry      = dy % SW;
    assign row     = 3'(dy / SW);
    assign cell_edge = (ry == 11'd0) || (ry == SW - 11'd1) || (dx == 11'd0) || (dx == SW - 11'd1);
    assign bar_top = BAR_BASE - STEP * {8'd0, shadow_width};
    assign bar     = in_rng(x, 11'd40, 11'd60) && (y >= bar_top) && (y <= BAR_END);

    logic       s1_panel, s1_outline, s1_preview, s1_grid, s1_col, s1_edge, s1_bar;
    logic [2:0] s1_row;
    logic [3:0] s1_color;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_panel   <= 1'b0;
            s1_outline <= 1'b0;
            s1_preview <= 1'b0;
            s1_grid    <= 1'b0;
            s1_col     <= 1'b0;
            s1_row     <= 3'd0;
            s1_edge    <= 1'b0;
            s1_bar     <= 1'b0;
            s1_color   <= 4'd0;
        end else begin
            s1_panel   <= (x <= PW);
            s1_outline <= sq18 && !sq20 && blink_phase;
            s1_preview <= sq20;
            s1_grid    <= grid_y && (col0 || col1);
            s1_col     <= col1;
            s1_row     <= row;
            s1_edge    <= cell_edge;
            s1_bar     <= bar;
            s1_color   <= shadow_color;
        end
    end

    // Stage 2: priority resolve and palette lookup.
    logic [23:0] rgb;
    logic [3:0]  grid_idx;

    assign grid_idx = {s1_col, s1_row};

    always_comb begin
        rgb = 24'h000000;
        if (!s1_panel)
            rgb = 24'h000000;
        else if (s1_outline)
            rgb = 24'hFFFFFF;
        else if (s1_preview)
            rgb = rom(s1_color);
        else if (s1_grid)
            rgb = (grid_idx == s1_color && s1_edge) ? 24'hFFFFFF : rom(grid_idx);
        else if (s1_bar)
            rgb = 24'hB9B9B9;
        else
            rgb = 24'h505050;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            red_out   <= 8'd0;
            green_out <= 8'd0;
            blue_out  <= 8'd0;
            in_sprite <= 1'b0;
        end else begin
            red_out   <= rgb[23:16];
            green_out <= rgb[15:8];
            blue_out  <= rgb[7:0];
            in_sprite <= s1_panel;
        end
    end

endmodule

// File: tb/tb_gui_panel.sv
// Scoreboarded directed bench for gui_panel; expected pixels queue up at issue and are retired two cycles later.
module tb_gui_panel;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        new_frame_in;
    logic [3:0]  cursor_color;
    logic [2:0]  stroke_width;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [7:0]  red_out, green_out, blue_out;
    logic        in_sprite;

    always #5 clk_in = ~clk_in;

    gui_panel #(.BLINK_FRAMES(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .new_frame_in (new_frame_in),
        .cursor_color (cursor_color),
        .stroke_width (stroke_width),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .red_out      (red_out),
        .green_out    (green_out),
        .blue_out     (blue_out),
        .in_sprite    (in_sprite)
    );

    int          checks = 0;
    int          errors = 0;
    logic [24:0] exp_q[$];
    string       name_q[$];
    logic        pix_vld = 1'b0;
    logic        vld_d1 = 1'b0;
    logic        vld_d2 = 1'b0;
    logic [24:0] got;
    logic [24:0] mon_exp;
    string       mon_name;

    // Reference blink state, advanced on every frame pulse the bench issues.
    int   bcnt   = 0;
    logic bphase = 1'b1;

    assign got = {in_sprite, red_out, green_out, blue_out};

    function automatic logic [24:0] px(input logic [23:0] c);
        return {1'b1, c};
    endfunction

    function automatic logic [24:0] outline_exp();
`ifdef GUI_PANEL_BLINK_EN
        return bphase ? px(24'hFFFFFF) : px(24'h505050);
`else
        return px(24'hFFFFFF);
`endif
    endfunction

    task automatic model_pulse();
        if (bcnt == 1) begin
            bcnt   = 0;
            bphase = ~bphase;
        end else begin
            bcnt = bcnt + 1;
        end
    endtask

    always @(posedge clk_in) begin
        vld_d1 <= pix_vld;
        vld_d2 <= vld_d1;
    end

    always @(negedge clk_in) begin
        if (vld_d2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, nothing expected", got);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (got !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", mon_name, got, mon_exp);
                end
            end
        end
    end

    task automatic pix(input int x, input int y, input logic [24:0] e, input string n, input bit pulse = 1'b0);
        @(posedge clk_in); #1;
        hcount_in    = 11'(x);
        vcount_in    = 10'(y);
        pix_vld      = 1'b1;
        new_frame_in = pulse;
        exp_q.push_back(e);
        name_q.push_back(n);
        if (pulse) model_pulse();
    endtask

    task automatic idle();
        @(posedge clk_in); #1;
        pix_vld      = 1'b0;
        new_frame_in = 1'b0;
        hcount_in    = 11'd2000;
        vcount_in    = 10'd0;
    endtask

    task automatic frame(input logic [3:0] c, input logic [2:0] w);
        @(posedge clk_in); #1;
        cursor_color = c;
        stroke_width = w;
        new_frame_in = 1'b1;
        pix_vld      = 1'b0;
        hcount_in    = 11'd2000;
        model_pulse();
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_in);
        @(negedge clk_in);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Feed an in-panel pixel so the outputs would be nonzero unless reset clears them.
    task automatic do_reset();
        @(posedge clk_in); #1;
        pix_vld      = 1'b0;
        new_frame_in = 1'b0;
        hcount_in    = 11'd50;
        vcount_in    = 10'd50;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (in_sprite !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_sprite: got %b expected 0", in_sprite);
        end
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h0) begin
            errors++;
            $display("FAIL reset_rgb: got %h expected 000000", {red_out, green_out, blue_out});
        end
        rst_in    = 1'b0;
        hcount_in = 11'd2000;
        bcnt      = 0;
        bphase    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_in       = 1'b1;
        new_frame_in = 1'b0;
        cursor_color = 4'h0;
        stroke_width = 3'd0;
        hcount_in    = 11'd2000;
        vcount_in    = 10'd0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        do_reset();
        pix(50, 50, px(24'hFFFFFF), "reset_shadow_white");

        frame(4'h9, 3'd0);
        pix(50, 50, px(24'h6C3082), "preview_eminence");
        cursor_color = 4'h2;
        pix(50, 50, px(24'h6C3082), "no_pulse_no_update");

        frame(4'd10, 3'd0);
        pix(60, 160, px(24'hFFFFFF), "grid_sel_ring");
        pix(70, 170, px(24'hFF0080), "grid_pink");
        pix(30, 130, px(24'h000000), "grid_black");
        pix(20, 120, px(24'h000000), "grid_corner_unsel");
        pix(79, 279, px(24'h80FF00), "grid_lime_last");
        pix(80, 160, px(24'h505050), "grid_right_excl");

        frame(4'd10, 3'd3);
        pix(50, 650, px(24'hB9B9B9), "bar_top");
        pix(50, 649, px(24'h505050), "bar_above");
        pix(60, 700, px(24'hB9B9B9), "bar_corner");
        pix(50, 701, px(24'h505050), "bar_below");
        pix(101, 650, 25'h0, "outside_panel");
        pix(100, 650, px(24'h505050), "panel_edge");
        drain();

        do_reset();
        pix(50, 50, px(24'hFFFFFF), "post_reset_white");
        pix(19, 50, outline_exp(), "blink_p0");
        for (int k = 1; k <= 4; k++) begin
            frame(4'h1, 3'd0);
            pix(19, 50, outline_exp(), $sformatf("blink_p%0d", k));
        end

        cursor_color = 4'h5;
        pix(50, 50, px(24'hFFFFFF), "same_cycle_old", 1'b1);
        pix(50, 50, px(24'h00FFFF), "same_cycle_next");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
